// File: rtl/ddr3_read_phase_tuner.sv
// Read-capture phase calibration: sweeps 8 read-clock phases, finds the widest circular passing window, seeks to its centre.
// Optional test-response watchdog enabled by defining PHASE_TUNER_TIMEOUT_EN.
module ddr3_read_phase_tuner #(
  parameter int TESTS_PER_POS = 4,
  parameter int STEP_PULSE    = 4,
  parameter int SETTLE_CYC    = 64,
  parameter int TIMEOUT_CYC   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cal_start_i,
  input  logic       pll_locked_i,
  output logic       test_req_o,
  input  logic       test_done_i,
  input  logic       test_pass_i,
  output logic       phase_step_o,
  output logic       phase_updn_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       cal_fail_o,
  output logic [7:0] pass_map_o,
  output logic [2:0] phase_pos_o
);

  // state     | meaning
  // S_IDLE    | waiting for cal_start
  // S_TEST    | issuing read-compare tests at the current phase
  // S_STEP_HI | phase_step pulse high
  // S_STEP_LO | settle time after a step
  // S_ANALYZE | 16-cycle circular scan of pass_map
  // S_SEEK    | step towards the window centre
  // S_DONE    | one-cycle completion state
  typedef enum logic [2:0] {
    S_IDLE, S_TEST, S_STEP_HI, S_STEP_LO, S_ANALYZE, S_SEEK, S_DONE
  } state_t;

  state_t      state_q;
  logic        test_req_q, phase_step_q, phase_updn_q, busy_q, done_q, cal_fail_q;
  logic [7:0]  pass_map_q;
  logic [2:0]  phase_pos_q;
  logic [15:0] tmr_q;
  logic [7:0]  tcnt_q;
  logic        pos_fail_q;
  logic [3:0]  sweep_cnt_q;
  logic        seeking_q;
  logic [3:0]  scan_idx_q, run_q, best_len_q;
  logic [2:0]  best_end_q, target_q;
`ifdef PHASE_TUNER_TIMEOUT_EN
  logic [31:0] wd_q;
`endif

  logic       scan_bit, resp_fail;
  logic [3:0] run_d, best_len_d;
  logic [2:0] best_end_d, start_d, half_d, target_d;

  always_comb begin
    scan_bit   = pass_map_q[scan_idx_q[2:0]];
    run_d      = scan_bit ? ((run_q == 4'd8) ? 4'd8 : run_q + 4'd1) : 4'd0;
    best_len_d = best_len_q;
    best_end_d = best_end_q;
    if (run_d > best_len_q) begin
      best_len_d = run_d;
      best_end_d = scan_idx_q[2:0];
    end
    // a full-length window (8) wraps to 0 in three bits, which is the intended start arithmetic
    start_d   = best_end_d - best_len_d[2:0] + 3'd1;
    half_d    = 3'((best_len_d - 4'd1) >> 1);
    target_d  = start_d + half_d;
    resp_fail = pos_fail_q | ~test_pass_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      test_req_q   <= 1'b0;
      phase_step_q <= 1'b0;
      phase_updn_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cal_fail_q   <= 1'b0;
      pass_map_q   <= 8'd0;
      phase_pos_q  <= 3'd0;
      tmr_q        <= 16'd0;
      tcnt_q       <= 8'd0;
      pos_fail_q   <= 1'b0;
      sweep_cnt_q  <= 4'd0;
      seeking_q    <= 1'b0;
      scan_idx_q   <= 4'd0;
      run_q        <= 4'd0;
      best_len_q   <= 4'd0;
      best_end_q   <= 3'd0;
      target_q     <= 3'd0;
`ifdef PHASE_TUNER_TIMEOUT_EN
      wd_q         <= 32'd0;
`endif
    end else if (state_q != S_IDLE && state_q != S_DONE && !pll_locked_i) begin
      test_req_q   <= 1'b0;
      phase_step_q <= 1'b0;
      cal_fail_q   <= 1'b1;
      done_q       <= 1'b1;
      busy_q       <= 1'b0;
      state_q      <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cal_start_i) begin
            if (pll_locked_i) begin
              done_q       <= 1'b0;
              cal_fail_q   <= 1'b0;
              pass_map_q   <= 8'd0;
              busy_q       <= 1'b1;
              test_req_q   <= 1'b1;
              phase_updn_q <= 1'b1;
              seeking_q    <= 1'b0;
              sweep_cnt_q  <= 4'd0;
              tcnt_q       <= 8'd0;
              pos_fail_q   <= 1'b0;
`ifdef PHASE_TUNER_TIMEOUT_EN
              wd_q         <= 32'(TIMEOUT_CYC - 1);
`endif
              state_q      <= S_TEST;
            end else begin
              done_q     <= 1'b1;
              cal_fail_q <= 1'b1;
            end
          end
        end
        S_TEST: begin
          if (test_req_q) begin
            if (test_done_i) begin
              test_req_q <= 1'b0;
              pos_fail_q <= resp_fail;
              if (tcnt_q == 8'(TESTS_PER_POS - 1)) begin
                pass_map_q[phase_pos_q] <= ~resp_fail;
                phase_step_q <= 1'b1;
                tmr_q        <= 16'(STEP_PULSE - 1);
                state_q      <= S_STEP_HI;
              end else begin
                tcnt_q <= tcnt_q + 8'd1;
              end
            end
`ifdef PHASE_TUNER_TIMEOUT_EN
            else if (wd_q == 32'd0) begin
              test_req_q <= 1'b0;
              cal_fail_q <= 1'b1;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              wd_q <= wd_q - 32'd1;
            end
`endif
          end else begin
            test_req_q <= 1'b1;
`ifdef PHASE_TUNER_TIMEOUT_EN
            wd_q       <= 32'(TIMEOUT_CYC - 1);
`endif
          end
        end
        S_STEP_HI: begin
          if (tmr_q == 16'd0) begin
            phase_step_q <= 1'b0;
            phase_pos_q  <= phase_updn_q ? phase_pos_q + 3'd1 : phase_pos_q - 3'd1;
            tmr_q        <= 16'(SETTLE_CYC - 1);
            if (!seeking_q) sweep_cnt_q <= sweep_cnt_q + 4'd1;
            state_q      <= S_STEP_LO;
          end else begin
            tmr_q <= tmr_q - 16'd1;
          end
        end
        S_STEP_LO: begin
          if (tmr_q == 16'd0) begin
            if (seeking_q) begin
              state_q <= S_SEEK;
            end else if (sweep_cnt_q < 4'd8) begin
              test_req_q <= 1'b1;
              tcnt_q     <= 8'd0;
              pos_fail_q <= 1'b0;
`ifdef PHASE_TUNER_TIMEOUT_EN
              wd_q       <= 32'(TIMEOUT_CYC - 1);
`endif
              state_q    <= S_TEST;
            end else begin
              scan_idx_q <= 4'd0;
              run_q      <= 4'd0;
              best_len_q <= 4'd0;
              best_end_q <= 3'd0;
              state_q    <= S_ANALYZE;
            end
          end else begin
            tmr_q <= tmr_q - 16'd1;
          end
        end
        S_ANALYZE: begin
          run_q      <= run_d;
          best_len_q <= best_len_d;
          best_end_q <= best_end_d;
          scan_idx_q <= scan_idx_q + 4'd1;
          if (scan_idx_q == 4'd15) begin
            if (best_len_d == 4'd0) begin
              cal_fail_q <= 1'b1;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_DONE;
            end else begin
              // direction is fixed here so it is stable a cycle before the first seek pulse
              target_q     <= target_d;
              phase_updn_q <= (target_d <= 3'd4);
              seeking_q    <= 1'b1;
              state_q      <= S_SEEK;
            end
          end
        end
        S_SEEK: begin
          if (phase_pos_q == target_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            phase_step_q <= 1'b1;
            tmr_q        <= 16'(STEP_PULSE - 1);
            state_q      <= S_STEP_HI;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // lock loss must silence the strobes in the very cycle it is seen
  assign test_req_o   = test_req_q & pll_locked_i;
  assign phase_step_o = phase_step_q & pll_locked_i;
  assign phase_updn_o = phase_updn_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign cal_fail_o   = cal_fail_q;
  assign pass_map_o   = pass_map_q;
  assign phase_pos_o  = phase_pos_q;

endmodule

// File: tb/tb_ddr3_read_phase_tuner.sv
// Self-checking bench for ddr3_read_phase_tuner: randomized test responses against a window-search model.
module tb_ddr3_read_phase_tuner;
  localparam int TPP     = 4;
  localparam int PULSE   = 4;
  localparam int SETTLE  = 64;
  localparam int TMO     = 4096;
  localparam int NTEST   = 8 * TPP;

  logic clk = 1'b0, rst = 1'b1;
  logic cal_start = 1'b0, pll_locked = 1'b1, test_done = 1'b0, test_pass = 1'b0;
  logic test_req, phase_step, phase_updn, busy, done, cal_fail;
  logic [7:0] pass_map;
  logic [2:0] phase_pos;

  int tests = 0, fails = 0;
  bit res [8][TPP];
  int resp_k, resp_delay;

  int ups = 0, downs = 0, gap_viol = 0, width_viol = 0, updn_viol = 0;
  int hi_cnt = 0, lo_cnt = 1000;
  logic prev_step = 1'b0, prev_updn = 1'b0, updn_at_rise = 1'b0;

  always #5 clk = ~clk;

  ddr3_read_phase_tuner #(.TESTS_PER_POS(TPP), .STEP_PULSE(PULSE), .SETTLE_CYC(SETTLE),
                          .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .cal_start_i(cal_start), .pll_locked_i(pll_locked),
    .test_req_o(test_req), .test_done_i(test_done), .test_pass_i(test_pass),
    .phase_step_o(phase_step), .phase_updn_o(phase_updn), .busy_o(busy), .done_o(done),
    .cal_fail_o(cal_fail), .pass_map_o(pass_map), .phase_pos_o(phase_pos));

  // step-strobe observer: direction counts, pulse width, settle gap, direction stability
  always @(negedge clk) begin
    if (rst) begin
      hi_cnt = 0; lo_cnt = 1000; prev_step = 1'b0;
    end else begin
      if (phase_step) begin
        if (!prev_step) begin
          if (phase_updn) ups++; else downs++;
          if (lo_cnt < SETTLE) gap_viol++;
          if (phase_updn !== prev_updn) updn_viol++;
          updn_at_rise = phase_updn;
          hi_cnt = 0;
        end
        hi_cnt++;
        if (phase_updn !== updn_at_rise) updn_viol++;
      end else begin
        if (prev_step) begin
          if (hi_cnt != PULSE) width_viol++;
          lo_cnt = 0;
        end
        lo_cnt++;
      end
      prev_step = phase_step;
    end
    prev_updn = phase_updn;
  end

  function automatic logic [7:0] exp_map_of();
    logic [7:0] m = 8'd0;
    for (int p = 0; p < 8; p++) begin
      m[p] = 1'b1;
      for (int t = 0; t < TPP; t++) if (!res[p][t]) m[p] = 1'b0;
    end
    return m;
  endfunction

  // widest circular run of ones; ties go to the run whose last position is reached first in a 0..15 scan
  function automatic void model(input logic [7:0] m, output int tgt, output bit fl);
    int bl = 0, bkey = 99, bs = 0;
    if (m == 8'hFF) begin tgt = 3; fl = 0; return; end
    for (int s = 0; s < 8; s++)
      for (int len = 1; len < 8; len++) begin
        bit ok = (m[(s + 7) % 8] == 1'b0) && (m[(s + len) % 8] == 1'b0);
        for (int j = 0; j < len; j++) if (!m[(s + j) % 8]) ok = 0;
        if (ok && (len > bl || (len == bl && s + len - 1 < bkey))) begin
          bl = len; bkey = s + len - 1; bs = s;
        end
      end
    fl  = (bl == 0);
    tgt = fl ? 0 : (bs + (bl - 1) / 2) % 8;
  endfunction

  task automatic set_pattern(input logic [7:0] m, input int single_pos);
    for (int p = 0; p < 8; p++) begin
      int fm = 0;
      if (!m[p]) fm = (p == single_pos) ? (1 << $urandom_range(0, TPP - 1)) : $urandom_range(1, 15);
      for (int t = 0; t < TPP; t++) res[p][t] = !fm[t];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; test_done = 1'b0; cal_start = 1'b0; pll_locked = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic respond_one();
    if (test_done) begin
      test_done = 1'b0; resp_k++;
    end else if (test_req && resp_k < NTEST) begin
      if (resp_delay == 0) begin
        test_done = 1'b1;
        test_pass = res[resp_k / TPP][resp_k % TPP];
        resp_delay = $urandom_range(0, 3);
      end else resp_delay--;
    end
  endtask

  task automatic start_cal();
    resp_k = 0; resp_delay = $urandom_range(0, 3);
    @(negedge clk) cal_start = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || test_req !== 1'b1) begin
      fails++; $display("FAIL start_edges busy=%b test_req=%b required 1/1", busy, test_req);
    end
    cal_start = 1'b0;
  endtask

  task automatic run_cal(input string name, input logic [7:0] m, input int single_pos, input bit poke);
    logic [7:0] em; int tgt, eu, ed, cyc = 0; bit fl, fin = 0, poked = 0;
    int u0, d0, g0, w0, v0;
    do_reset();
    set_pattern(m, single_pos);
    em = exp_map_of();
    model(em, tgt, fl);
    eu = 8 + ((!fl && tgt <= 4) ? tgt : 0);
    ed = (!fl && tgt > 4) ? 8 - tgt : 0;
    u0 = ups; d0 = downs; g0 = gap_viol; w0 = width_viol; v0 = updn_viol;
    start_cal();
    while (!fin && cyc < 20000) begin
      @(negedge clk); cyc++;
      cal_start = 1'b0;
      if (done) fin = 1;
      else respond_one();
      if (poke && !poked && resp_k == 10) begin cal_start = 1'b1; poked = 1; end
    end
    tests++;
    if (!fin) begin fails++; $display("FAIL %s timeout done=%b required 1", name, done); end
    tests++;
    if (pass_map !== em) begin fails++; $display("FAIL %s pass_map got %h required %h", name, pass_map, em); end
    tests++;
    if (cal_fail !== fl) begin fails++; $display("FAIL %s cal_fail got %b required %b", name, cal_fail, fl); end
    tests++;
    if (phase_pos !== 3'(tgt)) begin fails++; $display("FAIL %s phase_pos got %0d required %0d", name, phase_pos, tgt); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL %s busy got %b required 0", name, busy); end
    tests++;
    if (ups - u0 != eu || downs - d0 != ed) begin
      fails++; $display("FAIL %s steps got up=%0d down=%0d required up=%0d down=%0d", name, ups - u0, downs - d0, eu, ed);
    end
    tests++;
    if (gap_viol != g0 || width_viol != w0 || updn_viol != v0) begin
      fails++; $display("FAIL %s strobe_timing got gap=%0d width=%0d updn=%0d required 0", name,
                        gap_viol - g0, width_viol - w0, updn_viol - v0);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL %s done_level got %b required 1", name, done); end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({test_req, phase_step, phase_updn, busy, done, cal_fail} !== 6'd0) begin
      fails++; $display("FAIL reset_ctrl got %b required 000000", {test_req, phase_step, phase_updn, busy, done, cal_fail});
    end
    tests++;
    if (pass_map !== 8'd0 || phase_pos !== 3'd0) begin
      fails++; $display("FAIL reset_state got map=%h pos=%0d required 0/0", pass_map, phase_pos);
    end
  endtask

  task automatic test_patterns();
    run_cal("window_2_5", 8'b0011_1100, -1, 0);
    run_cal("wrap_window", 8'b1100_0011, -1, 0);
    run_cal("all_fail", 8'h00, -1, 0);
    run_cal("all_pass", 8'hFF, -1, 0);
    run_cal("single_fail_p5", 8'b1101_1111, 5, 1);
    for (int i = 0; i < 3; i++) run_cal("random_map", 8'($urandom), -1, 0);
  endtask

  task automatic test_unlocked_start();
    do_reset();
    pll_locked = 1'b0;
    @(negedge clk) cal_start = 1'b1;
    @(negedge clk) cal_start = 1'b0;
    tests++;
    if (done !== 1'b1 || cal_fail !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL unlocked_start got done=%b fail=%b busy=%b required 1/1/0", done, cal_fail, busy);
    end
    pll_locked = 1'b1;
  endtask

  task automatic test_lock_loss();
    int cyc = 0;
    do_reset();
    set_pattern(8'hFF, -1);
    start_cal();
    while (cyc < 5000) begin
      @(negedge clk); cyc++;
      respond_one();
      if (phase_step && !test_done) break;
    end
    tests++;
    if (phase_step !== 1'b1) begin fails++; $display("FAIL lock_loss_reach phase_step=%b required 1", phase_step); end
    pll_locked = 1'b0;
    #1;
    tests++;
    if (phase_step !== 1'b0 || test_req !== 1'b0) begin
      fails++; $display("FAIL lock_loss_strobe got step=%b req=%b required 0/0", phase_step, test_req);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || cal_fail !== 1'b1 || busy !== 1'b0 || phase_pos !== 3'd0) begin
      fails++; $display("FAIL lock_loss_status got done=%b fail=%b busy=%b pos=%0d required 1/1/0/0",
                        done, cal_fail, busy, phase_pos);
    end
    pll_locked = 1'b1;
  endtask

  task automatic test_reset_mid_sweep();
    int cyc = 0;
    do_reset();
    set_pattern(8'hFF, -1);
    start_cal();
    while (resp_k < 13 && cyc < 5000) begin
      @(negedge clk); cyc++;
      respond_one();
    end
    rst = 1'b1; test_done = 1'b0;
    @(negedge clk);
    tests++;
    if ({test_req, phase_step, phase_updn, busy, done, cal_fail, pass_map, phase_pos} !== 17'd0) begin
      fails++; $display("FAIL reset_mid_sweep got req=%b step=%b busy=%b done=%b map=%h pos=%0d required all 0",
                        test_req, phase_step, busy, done, pass_map, phase_pos);
    end
    rst = 1'b0;
  endtask

  task automatic test_no_response();
    int cyc = 0;
    do_reset();
    start_cal();
`ifdef PHASE_TUNER_TIMEOUT_EN
    while (!done && cyc < TMO + 50) begin @(negedge clk); cyc++; end
    tests++;
    if (done !== 1'b1 || cal_fail !== 1'b1 || cyc < TMO - 3 || cyc > TMO + 2) begin
      fails++; $display("FAIL timeout got done=%b fail=%b after %0d cycles required 1/1 near %0d", done, cal_fail, cyc, TMO);
    end
`else
    repeat (300) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || test_req !== 1'b1) begin
      fails++; $display("FAIL no_watchdog got busy=%b done=%b req=%b required 1/0/1", busy, done, test_req);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_unlocked_start();
    test_lock_loss();
    test_reset_mid_sweep();
    test_no_response();
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
